// File: rtl/calc_gen.sv
// calc_gen: decimal four-function calculator with a serial digit-refresh display.
// Optional build macro: CALC_GEN_DIV_EN adds the successive-subtraction divider (cmd D).
module calc_gen #(
    parameter int NDIG = 8,
    parameter int W    = 27
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              cmd,
    input  logic                    cmd_valid,
    output logic [1:0]              status,
    output logic [3:0]              data,
    output logic [$clog2(NDIG)-1:0] pos,
    output logic [2:0]              EA
);

    localparam int PW = $clog2(NDIG);

    function automatic longint pow10(input int n);
        longint v;
        v = 1;
        for (int i = 0; i < n; i++) v = v * 10;
        return v;
    endfunction

    localparam longint       MAXL = pow10(NDIG) - 1;
    localparam logic [W:0]   MAXV = (W+1)'(MAXL);
    localparam logic [W+3:0] MAXA = (W+4)'(MAXL);

    // Operator codes are the low two bits of the command nibble.
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [2:0] {
        ESPERA_A = 3'b000,
        ESPERA_B = 3'b001,
        OP       = 3'b010,
        CALC     = 3'b011,
        ERRO     = 3'b100
    } state_t;

    state_t         r_st;
    state_t         w_nx;
    logic [W-1:0]   r_entry;
    logic [W-1:0]   r_rega;
    logic [W-1:0]   r_regb;
    logic [1:0]     r_op;
    logic           r_fresh;
    logic           r_rf;
    logic [PW-1:0]  r_rk;
    logic [W-1:0]   r_disp;
    logic [W:0]     r_acc;
    logic [W-1:0]   r_cnt;
    logic           r_ovf;

    logic           w_acc_cmd;
    logic           w_isop;
    logic [W+3:0]   w_app;
    logic [W-1:0]   w_entry_nx;
    logic           w_fresh_nx;
    logic           w_ld_a;
    logic           w_op_ld;
    logic           w_go_calc;
    logic           w_start_rf;
    logic           w_calc_done;
    logic           w_calc_err;
    logic [W-1:0]   w_res;
    logic [W:0]     w_tot;
    logic [W:0]     w_acc_nx;
    logic [W-1:0]   w_cnt_nx;
    logic           w_ovf_nx;
    logic [W-1:0]   w_mmax;
    logic [W-1:0]   w_mmin;
    logic [W:0]     w_madd;
    logic [W-1:0]   w_dsrc;

`ifdef CALC_GEN_DIV_EN
    assign w_isop = (cmd >= 4'hA) && (cmd <= 4'hD);
`else
    assign w_isop = (cmd >= 4'hA) && (cmd <= 4'hC);
`endif

    assign w_acc_cmd = cmd_valid && (status == 2'b10);
    assign w_app     = {4'b0, r_entry} * (W+4)'(10) + (W+4)'(cmd);
    assign w_mmax    = (r_rega > r_regb) ? r_rega : r_regb;
    assign w_mmin    = (r_rega < r_entry) ? r_rega : r_entry;
    assign w_madd    = r_acc + {1'b0, w_mmax};

    // Outputs derive only from registers so reset takes effect without a clock.
    assign EA     = r_st;
    assign pos    = r_rf ? r_rk : '0;
    assign w_dsrc = r_rf ? r_disp : r_entry;
    always_comb begin
        status = 2'b10;
        data   = 4'(w_dsrc % W'(10));
        if (r_st == ERRO) begin
            status = 2'b00;
            data   = 4'hE;
        end else if (r_rf || r_st == CALC) begin
            status = 2'b01;
        end
    end

    // One CALC iteration: decides completion, result and the next accumulator.
    always_comb begin
        w_calc_done = 1'b0;
        w_calc_err  = 1'b0;
        w_res       = '0;
        w_tot       = '0;
        w_acc_nx    = r_acc;
        w_cnt_nx    = r_cnt;
        w_ovf_nx    = r_ovf;
        case (r_op)
            OP_ADD: begin
                w_tot       = {1'b0, r_rega} + {1'b0, r_regb};
                w_calc_done = 1'b1;
                w_calc_err  = w_tot > MAXV;
                w_res       = w_tot[W-1:0];
            end
            OP_SUB: begin
                w_calc_done = 1'b1;
                w_calc_err  = r_rega < r_regb;
                w_res       = r_rega - r_regb;
            end
            OP_MUL: begin
                if (r_cnt <= W'(1)) begin
                    w_tot       = (r_cnt == W'(1)) ? w_madd : r_acc;
                    w_calc_done = 1'b1;
                    w_calc_err  = r_ovf || (w_tot > MAXV);
                    w_res       = w_tot[W-1:0];
                end else begin
                    w_acc_nx = w_madd;
                    w_cnt_nx = r_cnt - W'(1);
                    w_ovf_nx = r_ovf || (w_madd > MAXV);
                end
            end
`ifdef CALC_GEN_DIV_EN
            OP_DIV: begin
                if (r_regb == '0) begin
                    w_calc_done = 1'b1;
                    w_calc_err  = 1'b1;
                end else if (r_acc >= {1'b0, r_regb}) begin
                    w_acc_nx = r_acc - {1'b0, r_regb};
                    w_cnt_nx = r_cnt + W'(1);
                end else begin
                    w_calc_done = 1'b1;
                    w_res       = r_cnt;
                end
            end
`endif
            default: w_calc_done = 1'b1;
        endcase
    end

    // Next state and datapath strobes from the accepted command or CALC progress.
    always_comb begin
        w_nx       = r_st;
        w_entry_nx = r_entry;
        w_fresh_nx = r_fresh;
        w_ld_a     = 1'b0;
        w_op_ld    = 1'b0;
        w_go_calc  = 1'b0;
        w_start_rf = 1'b0;
        unique case (r_st)
            ESPERA_A: if (w_acc_cmd) begin
                w_start_rf = 1'b1;
                if (cmd <= 4'd9) begin
                    if (r_fresh) begin
                        w_entry_nx = W'(cmd);
                        w_fresh_nx = 1'b0;
                    end else if (w_app <= MAXA) begin
                        w_entry_nx = w_app[W-1:0];
                    end
                end else if (cmd == 4'hF) begin
                    w_entry_nx = r_entry / W'(10);
                end else if (w_isop) begin
                    w_ld_a     = 1'b1;
                    w_op_ld    = 1'b1;
                    w_entry_nx = '0;
                    w_fresh_nx = 1'b0;
                    w_nx       = OP;
                end
            end
            ESPERA_B: if (w_acc_cmd) begin
                w_start_rf = 1'b1;
                if (cmd <= 4'd9) begin
                    if (w_app <= MAXA) w_entry_nx = w_app[W-1:0];
                end else if (cmd == 4'hF) begin
                    w_entry_nx = r_entry / W'(10);
                end else if (w_isop) begin
                    w_nx = ERRO;
                end else if (cmd == 4'hE) begin
                    // The display refresh for '=' is the one issued when CALC ends.
                    w_start_rf = 1'b0;
                    w_go_calc  = 1'b1;
                    w_nx       = CALC;
                end
            end
            OP: if (w_acc_cmd) begin
                w_start_rf = 1'b1;
                if (cmd <= 4'd9) begin
                    w_entry_nx = W'(cmd);
                    w_nx       = ESPERA_B;
                end else if (w_isop) begin
                    w_op_ld = 1'b1;
                end else if (cmd == 4'hE) begin
                    w_nx = ERRO;
                end
            end
            CALC: if (w_calc_done) begin
                w_start_rf = 1'b1;
                if (w_calc_err) begin
                    w_nx = ERRO;
                end else begin
                    w_entry_nx = w_res;
                    w_fresh_nx = 1'b1;
                    w_nx       = ESPERA_A;
                end
            end
            ERRO: w_nx = ERRO;
            default: w_nx = ESPERA_A;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_st <= ESPERA_A;
        else       r_st <= w_nx;
    end

    // Operand, arithmetic and display-refresh registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_entry <= '0;
            r_rega  <= '0;
            r_regb  <= '0;
            r_op    <= '0;
            r_fresh <= 1'b0;
            r_rf    <= 1'b0;
            r_rk    <= '0;
            r_disp  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_entry <= w_entry_nx;
            r_fresh <= w_fresh_nx;
            if (w_ld_a)  r_rega <= r_entry;
            if (w_op_ld) r_op   <= cmd[1:0];
            if (w_start_rf) begin
                r_rf   <= 1'b1;
                r_rk   <= '0;
                r_disp <= w_entry_nx;
            end else if (r_rf) begin
                if (r_rk == PW'(NDIG-1)) r_rf <= 1'b0;
                else                     r_rk <= r_rk + PW'(1);
                r_disp <= r_disp / W'(10);
            end
            if (w_go_calc) begin
                r_regb <= r_entry;
                r_ovf  <= 1'b0;
                r_acc  <= (r_op == OP_DIV) ? {1'b0, r_rega} : '0;
                r_cnt  <= (r_op == OP_MUL) ? w_mmin : '0;
            end else if (r_st == CALC && !w_calc_done) begin
                r_acc <= w_acc_nx;
                r_cnt <= w_cnt_nx;
                r_ovf <= w_ovf_nx;
            end
        end
    end

endmodule

// File: tb/tb_calc_gen.sv
// tb_calc_gen: calc_gen checked against a transaction-level arithmetic model.
// Honours CALC_GEN_DIV_EN the same way as the design.
`timescale 1ns/1ps
module tb_calc_gen;

    localparam int     NDIG = 8;
    localparam int     W    = 27;
    localparam int     PW   = $clog2(NDIG);
    localparam longint MAXN = 64'd99999999;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [1:0]    status;
    logic [3:0]    data;
    logic [PW-1:0] pos;
    logic [2:0]    EA;

    calc_gen #(.NDIG(NDIG), .W(W)) dut (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .status(status), .data(data), .pos(pos), .EA(EA)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // model state: 0 wait A, 1 wait B, 2 op, 4 error
    int     m_st;
    longint m_entry, m_rega, m_regb;
    int     m_op;
    bit     m_fresh;
    int     m_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit is_op(input int c);
`ifdef CALC_GEN_DIV_EN
        return c >= 10 && c <= 13;
`else
        return c >= 10 && c <= 12;
`endif
    endfunction

    task automatic model_reset();
        m_st = 0; m_entry = 0; m_rega = 0; m_regb = 0;
        m_op = 0; m_fresh = 0; m_cyc = 0;
    endtask

    task automatic model_calc();
        longint r;
        bit err;
        err = 0;
        r = 0;
        case (m_op)
            10: begin r = m_rega + m_regb; m_cyc = 1; end
            11: begin r = m_rega - m_regb; m_cyc = 1; end
            12: begin
                r = m_rega * m_regb;
                m_cyc = int'((m_rega < m_regb) ? m_rega : m_regb);
                if (m_cyc < 1) m_cyc = 1;
            end
            default: begin
                if (m_regb == 0) begin err = 1; m_cyc = 1; end
                else begin r = m_rega / m_regb; m_cyc = int'(r) + 1; end
            end
        endcase
        if (err || r < 0 || r > MAXN) m_st = 4;
        else begin m_entry = r; m_st = 0; m_fresh = 1; end
    endtask

    task automatic model(input int c);
        m_cyc = 0;
        case (m_st)
            0: begin
                if (c <= 9) begin
                    if (m_fresh) begin m_entry = c; m_fresh = 0; end
                    else if (m_entry * 10 + c <= MAXN) m_entry = m_entry * 10 + c;
                end else if (c == 15) m_entry = m_entry / 10;
                else if (is_op(c)) begin
                    m_rega = m_entry; m_entry = 0; m_op = c; m_fresh = 0; m_st = 2;
                end
            end
            1: begin
                if (c <= 9) begin
                    if (m_entry * 10 + c <= MAXN) m_entry = m_entry * 10 + c;
                end else if (c == 15) m_entry = m_entry / 10;
                else if (is_op(c)) m_st = 4;
                else if (c == 14) begin m_regb = m_entry; model_calc(); end
            end
            2: begin
                if (c <= 9) begin m_entry = c; m_st = 1; end
                else if (is_op(c)) m_op = c;
                else if (c == 14) m_st = 4;
            end
            default: ;
        endcase
    endtask

    task automatic poke(input bit en);
        if (en && $urandom_range(0, 2) == 0) begin
            cmd = 4'($urandom_range(0, 15));
            cmd_valid = 1'b1;
        end else cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_EA", EA, 0);
        chk("rst_status", status, 2);
        chk("rst_pos", pos, 0);
        chk("rst_data", data, 0);
        @(negedge clock);
        reset = 1'b0;
        cmd_valid = 1'b0;
        model_reset();
    endtask

    // Issue one accepted command and check every cycle until the display settles.
    task automatic do_cmd(input int c, input bit noise);
        int n;
        longint pw;
        n = 0;
        while (status != 2'b10 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (status != 2'b10) begin
            chk("ready_wait", status, 2);
            return;
        end
        cmd = 4'(c);
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        model(c);
        for (int i = 0; i < m_cyc; i++) begin
            chk("calc_EA", EA, 3);
            chk("calc_status", status, 1);
            poke(noise);
            @(negedge clock);
        end
        pw = 1;
        for (int k = 0; k < NDIG; k++) begin
            chk("rf_status", status, (m_st == 4) ? 0 : 1);
            chk("rf_pos", pos, k);
            chk("rf_data", data, (m_st == 4) ? 14 : (m_entry / pw) % 10);
            chk("rf_EA", EA, m_st);
            pw = pw * 10;
            poke(noise);
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        chk("idle_status", status, (m_st == 4) ? 0 : 2);
        chk("idle_pos", pos, 0);
        chk("idle_EA", EA, m_st);
        if (m_st != 4) chk("idle_data", data, m_entry % 10);
    endtask

    initial begin
        int c;
        cmd = 4'h0;
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        do_reset();

        // 12 + 34 = 46
        do_cmd(1, 0); do_cmd(2, 0); do_cmd(10, 0);
        do_cmd(3, 0); do_cmd(4, 0); do_cmd(14, 0);
        chk("lit_46", m_entry, 46);
        chk("lit_46_EA", EA, 0);
        chk("lit_46_d0", data, 6);

        // 7 * 9 = 63 in seven multiply cycles
        do_cmd(7, 0); do_cmd(12, 0); do_cmd(9, 0); do_cmd(14, 0);
        chk("lit_63", m_entry, 63);
        chk("lit_mulcyc", m_cyc, 7);
        chk("lit_63_d0", data, 3);

        // digit limit and backspace
        do_reset();
        for (int i = 0; i < 9; i++) do_cmd(9, 0);
        chk("lit_max", m_entry, 99999999);
        do_cmd(15, 0);
        chk("lit_bs", m_entry, 9999999);

        // busy pulses ignored, operator replaced in OP, new number after result
        do_reset();
        do_cmd(1, 1); do_cmd(1, 1); do_cmd(10, 1); do_cmd(11, 1);
        do_cmd(3, 1); do_cmd(14, 1);
        chk("lit_sub8", m_entry, 8);
        do_cmd(2, 1);
        chk("lit_new2", m_entry, 2);

        // negative result -> error, commands ignored afterwards
        do_reset();
        do_cmd(3, 0); do_cmd(11, 0); do_cmd(5, 0); do_cmd(14, 0);
        chk("lit_err_EA", EA, 4);
        for (int i = 0; i < 6; i++) begin
            cmd = 4'(i);
            cmd_valid = 1'b1;
            @(negedge clock);
            chk("err_hold_EA", EA, 4);
            chk("err_hold_status", status, 0);
            chk("err_hold_pos", pos, 0);
            chk("err_hold_data", data, 14);
        end
        cmd_valid = 1'b0;

        // add overflow -> error
        do_reset();
        for (int i = 0; i < 8; i++) do_cmd(9, 0);
        do_cmd(10, 0); do_cmd(1, 0); do_cmd(14, 0);
        chk("lit_ovf_EA", EA, 4);

`ifdef CALC_GEN_DIV_EN
        do_reset();
        do_cmd(9, 0); do_cmd(13, 0); do_cmd(0, 0); do_cmd(14, 0);
        chk("lit_div0_EA", EA, 4);
        do_reset();
        do_cmd(9, 0); do_cmd(13, 0); do_cmd(2, 0); do_cmd(14, 0);
        chk("lit_div_4", m_entry, 4);
        chk("lit_divcyc", m_cyc, 5);
`else
        do_reset();
        do_cmd(9, 0); do_cmd(13, 0);
        chk("lit_nodiv_EA", EA, 0);
        chk("lit_nodiv_9", m_entry, 9);
`endif

        // reset during CALC and during refresh leaves nothing behind
        do_reset();
        do_cmd(9, 0); do_cmd(9, 0); do_cmd(12, 0); do_cmd(9, 0); do_cmd(9, 0);
        cmd = 4'hE;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clock);
        chk("midcalc_EA", EA, 3);
        #2;
        do_reset();
        do_cmd(1, 0); do_cmd(10, 0); do_cmd(2, 0);
        cmd = 4'h5;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        chk("midrf_pos", pos, 1);
        #3;
        do_reset();
        do_cmd(1, 0); do_cmd(10, 0); do_cmd(2, 0); do_cmd(14, 0);
        chk("lit_after_rst", m_entry, 3);

        // randomized command stream
        do_reset();
        for (int it = 0; it < 300; it++) begin
            c = $urandom_range(0, 15);
            if (c <= 9 && m_st != 2 && !(m_st == 0 && m_fresh) && m_entry >= 100) c = 15;
            if (c == 14 && m_st == 1 && m_op == 13 && m_entry != 0 &&
                m_rega / m_entry > 3000) c = 15;
            do_cmd(c, $urandom_range(0, 1) == 1);
            if (m_st == 4) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
